// File: rtl/secure_port_receiver.sv
// Secure router port receiver: Hamming(7,4) single-error correction feeding a
// small valid/ready FIFO, with corrected-error statistics and a tamper-alarm FSM.
module secure_port_receiver #(
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8,
  parameter int WARN_TH  = 2,
  parameter int ALARM_TH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:6]               din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:3]               dout,
  output logic                     out_corr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         err_count,
  output logic                     alarm,
  input  logic                     clear_alarm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ALARM_TH + 1);

  typedef enum logic [1:0] {ST_OK, ST_WARN, ST_ALARM} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]      w_syn;
  logic [0:6]      w_cw;
  logic [0:3]      w_data;
  logic            w_corr;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  state_t          w_state_nxt;
  logic [CW-1:0]   w_consec_nxt;

  logic [4:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic [CNT_W-1:0] r_err;
  state_t          r_state;
  logic [CW-1:0]   r_consec;

  // Decode: syndrome names the 1-based position of the flipped bit
  always_comb begin
    w_syn[0] = din[0] ^ din[2] ^ din[4] ^ din[6];
    w_syn[1] = din[1] ^ din[2] ^ din[5] ^ din[6];
    w_syn[2] = din[3] ^ din[4] ^ din[5] ^ din[6];
    for (int i = 0; i < 7; i++) begin
      w_cw[i] = din[i] ^ (w_syn == 3'(i + 1));
    end
    w_data = {w_cw[2], w_cw[4], w_cw[5], w_cw[6]};
    w_corr = (w_syn != 3'd0);
  end

  assign w_full  = (r_count == (AW + 1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign in_ready = !w_full && (r_state != ST_ALARM);
  assign w_push  = in_valid && in_ready;
  assign w_pop   = !w_empty && out_ready;

  assign out_valid  = !w_empty;
  assign dout       = w_empty ? 4'b0000 : r_mem[r_rptr][4:1];
  assign out_corr   = w_empty ? 1'b0 : r_mem[r_rptr][0];
  assign fifo_count = r_count;
  assign err_count  = r_err;
  assign alarm      = (r_state == ST_ALARM);

  // Storage carries no reset; emptiness gates what is visible at the head
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_data, w_corr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_corr) r_err <= sat_inc(r_err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OK;
      r_consec <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_consec <= w_consec_nxt;
    end
  end

  // clear_alarm overrides any push-driven transition in the same cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_consec_nxt = r_consec;
    if (clear_alarm) begin
      w_state_nxt  = ST_OK;
      w_consec_nxt = '0;
    end else if (w_push) begin
      w_consec_nxt = w_corr ? r_consec + 1'b1 : '0;
      case (r_state)
        ST_OK: begin
          if (w_corr && (w_consec_nxt >= CW'(WARN_TH))) w_state_nxt = ST_WARN;
        end
        ST_WARN: begin
          if (!w_corr) w_state_nxt = ST_OK;
          else if (w_consec_nxt >= CW'(ALARM_TH)) w_state_nxt = ST_ALARM;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_port_receiver.sv
// Directed bench for secure_port_receiver: nearest-codeword reference model,
// per-cycle output comparison, and hand-computed literal expectations.
module tb_secure_port_receiver;

  localparam int DEPTH    = 4;
  localparam int CNT_W    = 8;
  localparam int WARN_TH  = 2;
  localparam int ALARM_TH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [0:6]       din;
  logic             out_valid;
  logic             out_ready;
  logic [0:3]       dout;
  logic             out_corr;
  logic [2:0]       fifo_count;
  logic [CNT_W-1:0] err_count;
  logic             alarm;
  logic             clear_alarm;

  int n_checks = 0;
  int n_errors = 0;

  secure_port_receiver #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .WARN_TH(WARN_TH), .ALARM_TH(ALARM_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_corr(out_corr), .fifo_count(fifo_count), .err_count(err_count),
    .alarm(alarm), .clear_alarm(clear_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [0:6] enc(input logic [0:3] d);
    return {d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3], d[0], d[1] ^ d[2] ^ d[3], d[1], d[2], d[3]};
  endfunction

  // Perfect code: every 7-bit word lies within distance 1 of exactly one codeword
  function automatic logic [4:0] model_decode(input logic [0:6] w);
    logic [4:0] r;
    logic [0:6] c;
    r = '0;
    for (int v = 0; v < 16; v++) begin
      c = enc(4'(v));
      if (c == w) r = {4'(v), 1'b0};
      else if ($countones(c ^ w) == 1) r = {4'(v), 1'b1};
    end
    return r;
  endfunction

  logic [4:0] mq[$];
  int         merr;
  int         mstate;
  int         mconsec;

  initial begin
    logic [4:0] e;
    bit         rdy;
    bit         push;
    bit         pop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        merr = 0;
        mstate = 0;
        mconsec = 0;
      end else begin
        rdy  = (mq.size() < DEPTH) && (mstate != 2);
        push = in_valid && rdy;
        pop  = (mq.size() > 0) && out_ready;
        e    = model_decode(din);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
        if (push && e[0] && merr < (1 << CNT_W) - 1) merr++;
        if (clear_alarm) begin
          mconsec = 0;
          mstate = 0;
        end else if (push) begin
          mconsec = e[0] ? mconsec + 1 : 0;
          mstate = (mconsec >= ALARM_TH) ? 2 : (mconsec >= WARN_TH) ? 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] head;
    head = (mq.size() > 0) ? mq[0] : 5'd0;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("dout", dout, head[4:1]);
    chk("out_corr", out_corr, head[0]);
    chk("fifo_count", fifo_count, mq.size());
    chk("err_count", err_count, merr);
    chk("alarm", alarm, mstate == 2);
    chk("in_ready", in_ready, (mq.size() < DEPTH) && (mstate != 2));
  end

  task automatic push_word(input logic [0:6] w);
    in_valid = 1'b1;
    din = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:6] clean;
    logic [0:6] w;
    logic [0:6] bp [5];
    clean = 7'b0110011;
    bp[0] = 7'b1101001;
    bp[1] = 7'b0101010;
    bp[2] = 7'b1000011;
    bp[3] = 7'b1001100;
    bp[4] = 7'b0100101;

    rst_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0; clear_alarm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_dout", dout, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    chk("model_clean", model_decode(clean), {4'b1011, 1'b0});
    chk("model_pos5", model_decode(7'b0110111), {4'b1011, 1'b1});
    chk("model_cw1", model_decode(7'b1101001), {4'b0001, 1'b0});

    @(posedge clk); #1;
    push_word(clean);
    chk("clean_valid", out_valid, 1);
    chk("clean_dout", dout, 4'b1011);
    chk("clean_corr", out_corr, 0);
    chk("clean_count", fifo_count, 1);
    chk("clean_err", err_count, 0);
    pop_one();
    chk("empty_valid", out_valid, 0);
    chk("empty_dout", dout, 0);

    for (int p = 0; p < 7; p++) begin
      w = clean;
      w[p] = ~w[p];
      push_word(w);
      chk("flip_dout", dout, 4'b1011);
      chk("flip_corr", out_corr, 1);
      pop_one();
      push_word(clean);
      chk("between_corr", out_corr, 0);
      pop_one();
    end
    chk("flip_err_total", err_count, 7);

    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = bp[i];
      @(posedge clk); #1;
    end
    din = bp[4];
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_count", fifo_count, 4);
    @(posedge clk); #1;
    chk("bp_held_count", fifo_count, 4);
    chk("bp_head0", dout, 4'b0001);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_pop_count", fifo_count, 3);
    chk("bp_pop_ready", in_ready, 1);
    chk("bp_head1", dout, 4'b0010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_5th_count", fifo_count, 3);
    chk("bp_head2", dout, 4'b0011);
    @(posedge clk); #1;
    chk("bp_head3", dout, 4'b0100);
    @(posedge clk); #1;
    chk("bp_head4", dout, 4'b0101);
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 0);
    out_ready = 1'b0;

    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("rst2_err", err_count, 0);
    @(posedge clk); #1;

    out_ready = 1'b1;
    w = clean;
    w[1] = ~w[1];
    for (int i = 0; i < 4; i++) begin
      push_word(w);
      if (i == 1) chk("esc_warn_alarm", alarm, 0);
      if (i == 2) chk("esc_3rd_alarm", alarm, 0);
    end
    chk("esc_alarm", alarm, 1);
    chk("esc_in_ready", in_ready, 0);
    chk("esc_err", err_count, 4);
    in_valid = 1'b1;
    din = clean;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("alarm_blocked_err", err_count, 4);
    chk("alarm_drained", fifo_count, 0);
    clear_alarm = 1'b1;
    @(posedge clk); #1;
    clear_alarm = 1'b0;
    chk("clear_alarm", alarm, 0);
    chk("clear_in_ready", in_ready, 1);

    push_word(w);
    push_word(w);
    push_word(clean);
    push_word(w);
    push_word(w);
    chk("recov_alarm", alarm, 0);
    chk("recov_in_ready", in_ready, 1);
    chk("recov_err", err_count, 8);
    @(posedge clk); #1;
    out_ready = 1'b0;

    clear_alarm = 1'b1;
    @(posedge clk); #1;
    clear_alarm = 1'b0;
    for (int i = 0; i < 4; i++) push_word(w);
    pop_one();
    chk("midrst_alarm_pre", alarm, 1);
    chk("midrst_count_pre", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", fifo_count, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_alarm", alarm, 0);
    chk("midrst_err", err_count, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/secure_port_receiver.md
Name: secure_port_receiver

Overview:
- Downstream consumer of one secure router output port; one instance per port (d_out0..d_out3).
- Accepts the 7-bit Hamming(7,4) codeword from the router, corrects any single-bit error and buffers the recovered 4-bit data nibble in a small FIFO with valid/ready handshake.
- Tracks corrected-error statistics and runs a tamper-alarm FSM that blocks the port after repeated corrupted words.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the corrected-error counter.
- WARN_TH, 2, consecutive corrected words that enter WARN.
- ALARM_TH, 4, consecutive corrected words that enter ALARM; must be greater than WARN_TH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  din holds a codeword.
- in_ready  output  1  receiver accepts a codeword this cycle.
- din  input  [0:6]  codeword; din[0]..din[6] = Hamming positions 1..7 = p1 p2 d1 p4 d2 d3 d4.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the head this cycle.
- dout  output  [0:3]  FIFO head data, ordered d1 d2 d3 d4.
- out_corr  output  1  FIFO head word needed a bit correction.
- fifo_count  output  [$clog2(DEPTH):0]  current occupancy.
- err_count  output  [CNT_W-1:0]  total corrected words; saturates.
- alarm  output  1  FSM is in ALARM.
- clear_alarm  input  1  one-cycle pulse that releases ALARM.

Behaviour:
- Reset, asynchronous on rst_n low:
  - FIFO empty; out_valid=0, dout=0, out_corr=0, fifo_count=0, err_count=0.
  - FSM in OK, consecutive-error counter 0, alarm=0.
  - in_ready=1 in the first cycle after rst_n is released.
  - Reset mid-operation discards all buffered words and statistics immediately.
- Syndrome, combinational on din:
  - s1 = din[0]^din[2]^din[4]^din[6]; s2 = din[1]^din[2]^din[5]^din[6]; s4 = din[3]^din[4]^din[5]^din[6].
  - syn = {s4,s2,s1}. If syn != 0, invert the bit at position syn (din[syn-1]) before extracting data; corr = (syn != 0).
  - A parity-only error (syn = 1, 2 or 4) still sets corr, but data is unchanged.
- Handshake:
  - in_ready = !full && state != ALARM. A push occurs when in_valid && in_ready.
  - A pop occurs when out_valid && out_ready.
  - Push writes {corrected data, corr} at the tail on the same rising edge. The word is visible at the head (out_valid=1) from the next cycle, so latency is 1 cycle when the FIFO was empty.
  - When full, in_ready=0 even if a pop occurs in the same cycle; no push while full.
  - When empty, out_valid=0 and dout and out_corr read 0.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH; FIFO order is strictly preserved.
- Statistics: err_count increments by 1 on every push with corr=1 and holds at 2^CNT_W-1.
- Alarm FSM (consec = consecutive-error counter):
  - OK: push with corr=1 increments consec; push with corr=0 clears consec. consec reaching WARN_TH moves to WARN.
  - WARN: push with corr=1 increments consec and moves to ALARM when consec reaches ALARM_TH. Push with corr=0 clears consec and returns to OK.
  - ALARM: alarm=1, in_ready=0, no pushes. The FIFO continues to drain normally.
  - ALARM exits only on clear_alarm=1: next state OK, consec=0.
  - clear_alarm in OK or WARN clears consec and forces OK.
  - Cycles with no push do not change consec.
  - The state transition takes effect on the same edge as the triggering push; in_ready drops in the following cycle.

Test Plan:
- Clean word: push din=7'b0110011 into an empty FIFO with out_ready=0 -> next cycle out_valid=1, dout=4'b1011, out_corr=0, fifo_count=1, err_count=0.
- Single-bit error: push din=7'b0110111 (position 5 flipped) -> dout=4'b1011, out_corr=1, err_count=1. Repeat flipping each of the 7 positions (with clean words between) -> dout=4'b1011 every time.
- Backpressure with DEPTH=4 and out_ready=0: five back-to-back valid words -> in_ready=0 after the 4th push and the 5th word is held. Raise out_ready -> entries pop in push order, and the 5th word is accepted in the cycle after the first pop.
- Alarm escalation: four consecutive corrupted words -> WARN after the 2nd, ALARM after the 4th; then alarm=1, in_ready=0 and err_count=4. A clear_alarm pulse -> alarm=0 and in_ready=1 next cycle.
- Recovery: two corrupted words, then a clean word -> FSM back in OK; two further corrupted words do not raise alarm.
- Reset mid-operation: with 3 words buffered and ALARM active, pulse rst_n low -> immediately fifo_count=0, out_valid=0, alarm=0, err_count=0.
